alu_issue_arbiter: RTL and testbench

Shares the single execute-stage ALU between the two decode/issue lanes of the superscalar core.
Picks at most one lane per cycle using round-robin priority, with a ready/valid handshake on each lane, and presents a registered micro-op to the ALU.
Holds off new issues while a multi-cycle multiply occupies the ALU.
Tags every issued op with its lane, so the ALU result and its instruction word return to the correct writeback lane after a fixed latency.

---
 rtl/alu_issue_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one execute-stage ALU between two issue lanes,
// with multiply stall handling and lane-tagged result return after a fixed ALU latency.
module alu_issue_arbiter #(
  parameter int unsigned ALU_LAT   = 2,
  parameter int unsigned MUL_STALL = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        l0_valid,
  output logic        l0_ready,
  input  logic [49:0] l0_uop,
  input  logic [15:0] l0_instr,
  input  logic        l1_valid,
  output logic        l1_ready,
  input  logic [49:0] l1_uop,
  input  logic [15:0] l1_instr,
  output logic [49:0] alu_uop,
  output logic [15:0] alu_instr,
  input  logic [15:0] alu_result,
  output logic        res_valid,
  output logic        res_lane,
  output logic [15:0] res_data,
  output logic [15:0] res_instr,
  output logic        busy
);

  localparam int unsigned UOP_W   = 50;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned MUL_BIT = 4;
  localparam int unsigned CNT_W   = (MUL_STALL > 1) ? $clog2(MUL_STALL + 1) : 1;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic               vld;
    logic               lane;
    logic [INSTR_W-1:0] instr;
  } trk_t;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rr_q, rr_d;
  logic [UOP_W-1:0]     uop_q, uop_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 iss_vld_q, iss_vld_d;
  logic                 iss_lane_q, iss_lane_d;
  trk_t [ALU_LAT-1:0]   trk_q, trk_d;

  logic                 grant0_c, grant1_c;
  logic                 any_trk_c;
  logic [UOP_W-1:0]     sel_uop_c;

  // Arbitration, multiply-stall FSM, ALU op register and result tracking next-state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    uop_d      = '0;
    instr_d    = '0;
    iss_vld_d  = 1'b0;
    iss_lane_d = 1'b0;
    grant0_c   = 1'b0;
    grant1_c   = 1'b0;
    sel_uop_c  = '0;
    any_trk_c  = 1'b0;

    trk_d[0] = '{vld: iss_vld_q, lane: iss_lane_q, instr: instr_q};
    for (int i = 1; i < int'(ALU_LAT); i++) begin
      trk_d[i] = trk_q[i-1];
    end

    if (!rst && !flush && state_q == IDLE) begin
      grant0_c = l0_valid && (!l1_valid || !rr_q);
      grant1_c = l1_valid && (!l0_valid || rr_q);
    end

    if (grant0_c || grant1_c) begin
      sel_uop_c  = grant1_c ? l1_uop : l0_uop;
      uop_d      = sel_uop_c;
      instr_d    = grant1_c ? l1_instr : l0_instr;
      iss_vld_d  = 1'b1;
      iss_lane_d = grant1_c;
      rr_d       = !grant1_c;
      if (sel_uop_c[MUL_BIT] && MUL_STALL != 0) begin
        state_d = MUL_WAIT;
        cnt_d   = CNT_W'(MUL_STALL);
      end
    end else if (state_q == MUL_WAIT) begin
      if (cnt_q <= CNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    // Mispredict: drop every in-flight op, including the one leaving the ALU register
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      for (int i = 0; i < int'(ALU_LAT); i++) begin
        trk_d[i].vld = 1'b0;
      end
    end

    for (int i = 0; i < int'(ALU_LAT); i++) begin
      any_trk_c = any_trk_c | trk_q[i].vld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      uop_q      <= '0;
      instr_q    <= '0;
      iss_vld_q  <= 1'b0;
      iss_lane_q <= 1'b0;
      trk_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      uop_q      <= uop_d;
      instr_q    <= instr_d;
      iss_vld_q  <= iss_vld_d;
      iss_lane_q <= iss_lane_d;
      trk_q      <= trk_d;
    end
  end

  assign l0_ready  = grant0_c;
  assign l1_ready  = grant1_c;
  assign alu_uop   = uop_q;
  assign alu_instr = instr_q;
  assign res_valid = trk_q[ALU_LAT-1].vld;
  assign res_lane  = trk_q[ALU_LAT-1].lane;
  assign res_instr = trk_q[ALU_LAT-1].instr;
  assign res_data  = alu_result;
  assign busy      = any_trk_c || (uop_q != '0) || (state_q == MUL_WAIT);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Randomized scoreboard bench for alu_issue_arbiter: lane/stall/flush/reset reference
// model on the stimulus side, decoupled monitor checking ALU drive and returned results.
module tb_alu_issue_arbiter;

  localparam int unsigned ALU_LAT   = 2;
  localparam int unsigned MUL_STALL = 2;
  localparam int          NCYC      = 3000;
  localparam int          TAIL      = 20;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        l0_valid, l0_ready, l1_valid, l1_ready;
  logic [49:0] l0_uop, l1_uop, alu_uop;
  logic [15:0] l0_instr, l1_instr, alu_instr, alu_result;
  logic        res_valid, res_lane, busy;
  logic [15:0] res_data, res_instr;

  always #5 clk = ~clk;

  alu_issue_arbiter #(.ALU_LAT(ALU_LAT), .MUL_STALL(MUL_STALL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .l0_valid(l0_valid), .l0_ready(l0_ready), .l0_uop(l0_uop), .l0_instr(l0_instr),
    .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_uop(l1_uop), .l1_instr(l1_instr),
    .alu_uop(alu_uop), .alu_instr(alu_instr), .alu_result(alu_result),
    .res_valid(res_valid), .res_lane(res_lane), .res_data(res_data),
    .res_instr(res_instr), .busy(busy)
  );

  typedef struct {
    int          lane;
    logic [15:0] instr;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = -1;
  logic        checking = 1'b0;
  logic [49:0] exp_alu_uop = '0;
  logic [15:0] exp_alu_instr = '0;

  // ALU behaviour: add op1+op2, an empty alusignals field produces 0
  function automatic logic [15:0] alu_fn(input logic [49:0] u);
    logic [15:0] a = u[27:12];
    logic [15:0] b = u[43:28];
    return (u[11:0] == 12'h0) ? 16'h0 : 16'(a + b);
  endfunction

  function automatic logic [49:0] rand_uop();
    logic [11:0] s = 12'($urandom);
    logic [49:0] u;
    s[4] = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 7) == 0) s = '0;
    u = {1'($urandom), 5'($urandom), 16'($urandom), 16'($urandom), s};
    if (u == '0) u[12] = 1'b1;
    return u;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // ALU emulation: result of the op presented ALU_LAT cycles earlier
  logic [49:0] hist[$];
  always @(negedge clk) begin
    hist.push_back(alu_uop);
    if (hist.size() > ALU_LAT) void'(hist.pop_front());
  end
  always @(posedge clk) begin
    #1;
    alu_result = (hist.size() == ALU_LAT) ? alu_fn(hist[0]) : 16'h0;
  end

  // Monitor: ALU drive every cycle, results popped from the scoreboard when presented
  always @(negedge clk) begin
    if (checking) begin
      check("alu_uop", 64'(alu_uop), 64'(exp_alu_uop));
      check("alu_instr", 64'(alu_instr), 64'(exp_alu_instr));
      if (res_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("res_unexpected", 64'(1), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          check("res_due", 64'(cyc), 64'(mon_e.due));
          check("res_lane", 64'(res_lane), 64'(mon_e.lane));
          check("res_instr", 64'(res_instr), 64'(mon_e.instr));
          check("res_data", 64'(res_data), 64'(mon_e.data));
        end
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        check("res_missing", 64'(0), 64'(1));
        void'(sb.pop_front());
      end
    end
  end

  logic        v[2];
  logic [49:0] u[2];
  logic [15:0] ins[2];
  int          rr_m, blk_until, k;
  int          due_l[$];
  logic        rst_now, flush_now, blocked, r0, r1, busy_m;

  task automatic drive_lanes();
    l0_valid = v[0]; l0_uop = u[0]; l0_instr = ins[0];
    l1_valid = v[1]; l1_uop = u[1]; l1_instr = ins[1];
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b1; u[i] = rand_uop(); ins[i] = 16'($urandom);
    end
    drive_lanes();
    repeat (2) @(posedge clk);
    #1;
    check("rst_l0_ready", 64'(l0_ready), 64'(0));
    check("rst_l1_ready", 64'(l1_ready), 64'(0));
    check("rst_alu_uop", 64'(alu_uop), 64'(0));
    check("rst_alu_instr", 64'(alu_instr), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_lane", 64'(res_lane), 64'(0));
    check("rst_res_instr", 64'(res_instr), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rr_m = 0; blk_until = -1;
    checking = 1'b1;

    for (int c = 0; c < NCYC + TAIL; c++) begin
      cyc = c;
      rst_now   = (c < NCYC - TAIL) && ($urandom_range(0, 99) == 0);
      flush_now = !rst_now && (c < NCYC - TAIL) && ($urandom_range(0, 24) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && c < NCYC && $urandom_range(0, 3) != 0) begin
          v[i] = 1'b1; u[i] = rand_uop(); ins[i] = 16'($urandom);
        end
      end
      rst = rst_now; flush = flush_now;
      drive_lanes();

      while (due_l.size() > 0 && due_l[0] < c) void'(due_l.pop_front());
      blocked = rst_now || flush_now || (c <= blk_until);
      r0 = !blocked && v[0] && (!v[1] || rr_m == 0);
      r1 = !blocked && v[1] && (!v[0] || rr_m == 1);
      busy_m = (c <= blk_until) || (due_l.size() > 0);

      @(negedge clk);
      check("l0_ready", 64'(l0_ready), 64'(r0));
      check("l1_ready", 64'(l1_ready), 64'(r1));
      check("busy", 64'(busy), 64'(busy_m));

      @(posedge clk);
      #1;
      if (rst_now || flush_now) begin
        sb.delete(); due_l.delete();
        blk_until = -1;
        if (rst_now) rr_m = 0;
        exp_alu_uop = '0; exp_alu_instr = '0;
      end else if (r0 || r1) begin
        k = r1 ? 1 : 0;
        rr_m = 1 - k;
        sb.push_back('{lane: k, instr: ins[k], data: alu_fn(u[k]), due: c + 1 + int'(ALU_LAT)});
        due_l.push_back(c + 1 + int'(ALU_LAT));
        exp_alu_uop = u[k]; exp_alu_instr = ins[k];
        if (u[k][4] && MUL_STALL > 0) blk_until = c + int'(MUL_STALL);
        v[k] = 1'b0;
      end else begin
        exp_alu_uop = '0; exp_alu_instr = '0;
      end
    end

    cyc = NCYC + TAIL;
    check("drain_sb_empty", 64'(sb.size()), 64'(0));
    check("drain_lanes_idle", 64'({v[1], v[0]}), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
